// File: rtl/julia_dispatch.sv
// Raster-scan job issuer for the Julia worker array: round-robin hands pixel jobs to idle workers.
// Optional JULIA_DISPATCH_STALL_CNT_EN adds a saturating stall_cycles counter output.
module julia_dispatch #(
    parameter int NUM_JULIA = 8,
    parameter int X_BITS    = 10,
    parameter int Y_BITS    = 10,
    parameter int ADDR_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic [ADDR_BITS-1:0] frame_base,
    input  logic [X_BITS-1:0]    width,
    input  logic [Y_BITS-1:0]    height,
    input  logic [NUM_JULIA-1:0] idle,
    output logic [NUM_JULIA-1:0] start,
    output logic [X_BITS-1:0]    job_x,
    output logic [Y_BITS-1:0]    job_y,
    output logic [ADDR_BITS-1:0] job_address,
    output logic                 busy,
    output logic                 frame_done
`ifdef JULIA_DISPATCH_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cycles
`endif
);

    localparam int PTR_BITS = (NUM_JULIA > 1) ? $clog2(NUM_JULIA) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [ADDR_BITS-1:0] base_r;
    logic [X_BITS-1:0]    w_r;
    logic [Y_BITS-1:0]    h_r;
    logic [X_BITS-1:0]    x;
    logic [Y_BITS-1:0]    y;
    logic [ADDR_BITS-1:0] lin;
    logic [PTR_BITS-1:0]  ptr;

    logic [NUM_JULIA-1:0] eligible;
    logic                 grant_valid;
    logic [PTR_BITS-1:0]  grant_idx;
    logic [PTR_BITS-1:0]  cand;
    logic                 accept;
    logic                 issue;
    logic                 last_pixel;
    logic                 line_end;
    logic [NUM_JULIA-1:0] start_next;
    logic                 busy_next;
    logic                 frame_done_next;

    // The registered start doubles as the just-started mask, hiding each worker's idle deassert latency.
    assign eligible   = idle & ~start;
    assign accept     = (state == S_IDLE) && go;
    assign issue      = (state == S_ISSUE) && grant_valid;
    assign line_end   = (x == w_r - X_BITS'(1));
    assign last_pixel = line_end && (y == h_r - Y_BITS'(1));

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= NUM_JULIA; i++) begin
            cand = PTR_BITS'((int'(ptr) + i) % NUM_JULIA);
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (go) begin
                    state_next = (width == '0 || height == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (grant_valid && last_pixel) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (&eligible) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        start_next      = '0;
        busy_next       = 1'b0;
        frame_done_next = 1'b0;
        case (state)
            S_IDLE:  busy_next = go;
            S_ISSUE: begin
                busy_next = 1'b1;
                if (grant_valid) begin
                    start_next = NUM_JULIA'(1) << grant_idx;
                end
            end
            S_DRAIN: busy_next = 1'b1;
            S_DONE:  frame_done_next = 1'b1;
            default: busy_next = 1'b0;
        endcase
    end

    // Linear pixel counter replaces y*width+x so the address path needs only an adder.
    always_ff @(posedge clk) begin
        if (rst) begin
            start       <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            job_x       <= '0;
            job_y       <= '0;
            job_address <= '0;
            base_r      <= '0;
            w_r         <= '0;
            h_r         <= '0;
            x           <= '0;
            y           <= '0;
            lin         <= '0;
            ptr         <= PTR_BITS'(NUM_JULIA - 1);
        end else begin
            start      <= start_next;
            busy       <= busy_next;
            frame_done <= frame_done_next;
            if (accept) begin
                base_r <= frame_base;
                w_r    <= width;
                h_r    <= height;
                x      <= '0;
                y      <= '0;
                lin    <= '0;
            end
            if (issue) begin
                job_x       <= x;
                job_y       <= y;
                job_address <= base_r + lin;
                ptr         <= grant_idx;
                lin         <= lin + ADDR_BITS'(1);
                if (line_end) begin
                    x <= '0;
                    y <= y + Y_BITS'(1);
                end else begin
                    x <= x + X_BITS'(1);
                end
            end
        end
    end

`ifdef JULIA_DISPATCH_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            stall_cycles <= '0;
        end else if (state == S_ISSUE && !grant_valid && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_julia_dispatch.sv
// Self-checking bench for julia_dispatch: directed frame table, worker-idle scenarios, mid-frame
// reset and randomized idle patterns checked against a raster/round-robin reference model.
module tb_julia_dispatch;

    localparam int NJ = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [31:0] frame_base;
    logic [9:0]  width;
    logic [9:0]  height;
    logic [7:0]  idle;
    logic [7:0]  start;
    logic [9:0]  job_x;
    logic [9:0]  job_y;
    logic [31:0] job_address;
    logic        busy;
    logic        frame_done;
`ifdef JULIA_DISPATCH_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    julia_dispatch #(
        .NUM_JULIA(NJ),
        .X_BITS(10),
        .Y_BITS(10),
        .ADDR_BITS(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .go(go),
        .frame_base(frame_base),
        .width(width),
        .height(height),
        .idle(idle),
        .start(start),
        .job_x(job_x),
        .job_y(job_y),
        .job_address(job_address),
        .busy(busy),
        .frame_done(frame_done)
`ifdef JULIA_DISPATCH_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] base;
        int          w;
        int          h;
        int          exp_starts;
        int          exp_done;
        logic [31:0] exp_last;
    } vec_t;

    int compared   = 0;
    int mismatched = 0;
    int last_worker = NJ - 1;
    int wcnt [NJ];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Model: pixels issued in raster order, one per edge, to the first idle-and-not-just-started
    // worker after the previous grant; frame_done one edge after the drain sees every worker free.
    task automatic run_frame(input logic [31:0] b, input int w, input int h, input int mode,
                             input logic [7:0] mask, output int nstarts, output int done_k,
                             output logic [31:0] first_addr, output logic [31:0] last_addr);
        int          n;
        int          idx;
        int          px;
        int          py;
        int          cw;
        logic [7:0]  prev_exp;
        logic [7:0]  exp_start;
        logic [7:0]  elig;
        logic [7:0]  idle_now;
        logic [31:0] exp_addr;
        logic        done_next;
        logic        exp_done;
        bit          finished;
        n = w * h;
        idx = 0;
        px = 0;
        py = 0;
        prev_exp = '0;
        exp_addr = '0;
        finished = 0;
        nstarts = 0;
        done_k = 0;
        first_addr = '0;
        last_addr = '0;
        foreach (wcnt[i]) wcnt[i] = 0;
        go = 1'b1;
        frame_base = b;
        width = 10'(w);
        height = 10'(h);
        tick();
        go = 1'b0;
        check_output("busy_after_go", 64'(busy), 64'(1));
        done_next = (n == 0);
        for (int k = 1; !finished; k++) begin
            if (k > 3000) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL frame_timeout: got no frame_done after %0d cycles, want one", k);
                break;
            end
            case (mode)
                0: idle_now = '1;
                1: idle_now = (idx < n) ? mask : 8'hFF;
                2: begin
                    idle_now = 8'($urandom);
                    if (idx >= n && $urandom_range(0, 3) == 0) idle_now = 8'hFF;
                end
                3: for (int i = 0; i < NJ; i++) idle_now[i] = (wcnt[i] == 0);
                default: idle_now = (k <= 5) ? 8'h00 : 8'hFF;
            endcase
            idle = idle_now;
            if (mode == 2) begin
                go = 1'($urandom);
                frame_base = $urandom;
                width = 10'($urandom_range(0, 7));
                height = 10'($urandom_range(0, 7));
            end
            exp_done = done_next;
            done_next = 1'b0;
            exp_start = '0;
            elig = idle_now & ~prev_exp;
            if (!exp_done) begin
                if (idx < n) begin
                    if (elig != '0) begin
                        for (int j = 1; j <= NJ; j++) begin
                            cw = (last_worker + j) % NJ;
                            if (exp_start == '0 && elig[cw]) begin
                                exp_start = 8'(1) << cw;
                                last_worker = cw;
                            end
                        end
                        px = idx % w;
                        py = idx / w;
                        exp_addr = b + 32'(py * w + px);
                        idx++;
                    end
                end else if (elig == 8'hFF) begin
                    done_next = 1'b1;
                end
            end
            prev_exp = exp_start;
            tick();
            check_output("start", 64'(start), 64'(exp_start));
            check_output("frame_done", 64'(frame_done), 64'(exp_done));
            check_output("busy", 64'(busy), 64'(!exp_done));
            if (exp_start != '0) begin
                check_output("job_x", 64'(job_x), 64'(px));
                check_output("job_y", 64'(job_y), 64'(py));
                check_output("job_address", 64'(job_address), 64'(exp_addr));
            end
            if (start != '0) begin
                nstarts++;
                last_addr = job_address;
                if (nstarts == 1) first_addr = job_address;
            end
            if (frame_done && done_k == 0) done_k = k;
            if (mode == 3) begin
                for (int i = 0; i < NJ; i++) begin
                    if (wcnt[i] > 0) wcnt[i]--;
                    if (start[i]) wcnt[i] = 10;
                end
            end
            if (exp_done) finished = 1;
        end
        go = 1'b0;
        idle = 8'hFF;
    endtask

    initial begin
        vec_t        vecs [6];
        int          ns;
        int          dk;
        logic [31:0] fa;
        logic [31:0] la;

        vecs[0] = '{32'h0000_1000, 4, 2, 8, 11, 32'h0000_1007};
        vecs[1] = '{32'h0000_0000, 0, 5, 0, 1, 32'h0};
        vecs[2] = '{32'h0000_0020, 5, 0, 0, 1, 32'h0};
        vecs[3] = '{32'hFFFF_FFFE, 3, 1, 3, 6, 32'h0};
        vecs[4] = '{32'h0000_0100, 1, 1, 1, 4, 32'h0000_0100};
        vecs[5] = '{32'h0000_0000, 10, 3, 30, 33, 32'h0000_001D};

        rst = 1'b1;
        go = 1'b0;
        idle = 8'hFF;
        frame_base = '0;
        width = '0;
        height = '0;
        tick();
        tick();
        check_output("reset_start", 64'(start), 64'(0));
        check_output("reset_job_x", 64'(job_x), 64'(0));
        check_output("reset_job_y", 64'(job_y), 64'(0));
        check_output("reset_job_address", 64'(job_address), 64'(0));
        check_output("reset_busy", 64'(busy), 64'(0));
        check_output("reset_frame_done", 64'(frame_done), 64'(0));
        rst = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].base, vecs[v].w, vecs[v].h, 0, 8'hFF, ns, dk, fa, la);
            check_output("table_starts", 64'(ns), 64'(vecs[v].exp_starts));
            check_output("table_done_latency", 64'(dk), 64'(vecs[v].exp_done));
            check_output("table_last_address", 64'(la), 64'(vecs[v].exp_last));
            tick();
        end

        // Only worker 2 idle: starts must be spaced by the just-started mask.
        run_frame(32'h0000_4000, 3, 1, 1, 8'b0000_0100, ns, dk, fa, la);
        check_output("single_worker_starts", 64'(ns), 64'(3));
        check_output("single_worker_done", 64'(dk), 64'(8));
        tick();

        // Workers stay busy 10 cycles after each start; drain waits for the last one.
        run_frame(32'h0000_5000, 3, 1, 3, 8'hFF, ns, dk, fa, la);
        check_output("drain_starts", 64'(ns), 64'(3));
        check_output("drain_done", 64'(dk), 64'(15));
        tick();

        // Reset mid-frame after three issues, then restart from pixel (0,0).
        go = 1'b1;
        frame_base = 32'h0000_2000;
        width = 10'd4;
        height = 10'd2;
        tick();
        go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("pre_reset_issue", 64'(start != '0), 64'(1));
        end
        rst = 1'b1;
        tick();
        check_output("midreset_start", 64'(start), 64'(0));
        check_output("midreset_busy", 64'(busy), 64'(0));
        check_output("midreset_frame_done", 64'(frame_done), 64'(0));
        rst = 1'b0;
        last_worker = NJ - 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_output("post_reset_quiet", 64'({start, busy, frame_done}), 64'(0));
        end
        run_frame(32'h0000_3000, 2, 2, 0, 8'hFF, ns, dk, fa, la);
        check_output("restart_first_address", 64'(fa), 64'(32'h0000_3000));
        check_output("restart_starts", 64'(ns), 64'(4));
        tick();

        for (int r = 0; r < 20; r++) begin
            int rw;
            int rh;
            rw = $urandom_range(1, 6);
            rh = $urandom_range(0, 4);
            run_frame($urandom, rw, rh, 2, 8'hFF, ns, dk, fa, la);
            check_output("random_starts", 64'(ns), 64'(rw * rh));
            tick();
        end

`ifdef JULIA_DISPATCH_STALL_CNT_EN
        run_frame(32'h0000_6000, 4, 1, 4, 8'hFF, ns, dk, fa, la);
        check_output("stall_done", 64'(dk), 64'(12));
        tick();
        check_output("stall_cycles_held", 64'(stall_cycles), 64'(5));
        go = 1'b1;
        width = 10'd1;
        height = 10'd1;
        tick();
        go = 1'b0;
        check_output("stall_cycles_cleared", 64'(stall_cycles), 64'(0));
        begin
            bit seen;
            seen = 0;
            for (int k = 0; k < 50 && !seen; k++) begin
                tick();
                if (frame_done) seen = 1;
            end
            check_output("stall_second_frame_done", 64'(seen), 64'(1));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
